// File: rtl/mem_access_unit.sv
// mem_access_unit: RV64 load/store unit in front of the unified RAM rw port.
// Turns byte-addressed CPU loads/stores into 8-byte RAM word beats with a
// byte-lane mask, and sign/zero-extends load data on the way back.
//
// Optional feature macro: MISALIGN_SPLIT_EN
//   defined   - accesses crossing an 8-byte boundary run as two beats (ACC0, ACC1)
//   undefined - such accesses are rejected with resp_err and touch no RAM
//
// Handshake: a request is accepted on a rising clk edge where req_valid and
// req_ready are both 1; req_ready is 1 only in IDLE. The response is a single
// cycle resp_valid pulse with no back-pressure, so the CPU must sample it.
module mem_access_unit #(
  parameter int ADDR_W = 33,
  parameter int XLEN   = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              rw_wmode,
  output logic [ADDR_W-1:0] rw_addr,
  output logic [XLEN-1:0]   rw_wdata,
  output logic [7:0]        rw_wmask,
  input  logic [XLEN-1:0]   rw_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [XLEN-1:0]     wdata_q;
  logic                err_q;
  logic [XLEN-1:0]     lo_q;
  logic [ADDR_W-1:0]   last_addr_q;

  logic                accept;
  logic                req_bad;
  logic [2:0]          o;
  logic [7:0]          base_mask;
  logic [ADDR_W-1:0]   beat0_addr;
  logic [XLEN-1:0]     ld_sh;
  logic [XLEN-1:0]     ld_ext;

  // Upper request address bits are outside the RAM and deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[XLEN-1:ADDR_W];

  assign accept     = req_valid && (state_q == IDLE);
  assign o          = addr_q[2:0];
  assign beat0_addr = {addr_q[ADDR_W-1:3], 3'b000};
  assign dbg_state  = state_q;

  // Size decode of the captured request: funct3[1:0] selects 1/2/4/8 bytes.
  always_comb begin
    base_mask = 8'h01;
    case (f3_q[1:0])
      2'd0: base_mask = 8'h01;
      2'd1: base_mask = 8'h03;
      2'd2: base_mask = 8'h0F;
      2'd3: base_mask = 8'hFF;
      default: base_mask = 8'h01;
    endcase
  end

`ifdef MISALIGN_SPLIT_EN
  logic [XLEN-1:0]   hi_q;
  logic [15:0]       mask16;
  logic [127:0]      w128;
  logic [3:0]        cap_size;
  logic              cross_q;
  logic [ADDR_W-1:0] beat1_addr;

  assign cap_size   = 4'd1 << f3_q[1:0];
  assign cross_q    = ({1'b0, o} + cap_size) > 4'd8;
  assign mask16     = {8'h00, base_mask} << o;
  assign w128       = {64'h0, wdata_q} << {o, 3'b000};
  assign beat1_addr = beat0_addr + ADDR_W'(8);
  assign ld_sh      = 64'({hi_q, lo_q} >> {o, 3'b000});
  // Illegal encodings only; crossing accesses are executed as two beats.
  assign req_bad    = (req_funct3 == 3'd7) || (req_we && req_funct3[2]);
`else
  logic [3:0] req_size;
  logic       req_cross;

  assign req_size  = 4'd1 << req_funct3[1:0];
  assign req_cross = ({1'b0, req_addr[2:0]} + req_size) > 4'd8;
  assign ld_sh     = lo_q >> {o, 3'b000};
  // Illegal encodings, plus any access that would need a second beat.
  assign req_bad   = (req_funct3 == 3'd7) || (req_we && req_funct3[2]) || req_cross;
`endif

  // Load data extraction: truncate to the access size, then extend by funct3.
  always_comb begin
    ld_ext = '0;
    case (f3_q)
      3'd0: ld_ext = {{56{ld_sh[7]}},  ld_sh[7:0]};
      3'd1: ld_ext = {{48{ld_sh[15]}}, ld_sh[15:0]};
      3'd2: ld_ext = {{32{ld_sh[31]}}, ld_sh[31:0]};
      3'd3: ld_ext = ld_sh;
      3'd4: ld_ext = {56'h0, ld_sh[7:0]};
      3'd5: ld_ext = {48'h0, ld_sh[15:0]};
      3'd6: ld_ext = {32'h0, ld_sh[31:0]};
      default: ld_ext = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and all port outputs, decoded from the current state.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    rw_wmode   = 1'b0;
    rw_wmask   = 8'h00;
    rw_wdata   = '0;
    rw_addr    = last_addr_q;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_bad ? RESP : ACC0;
      end
      ACC0: begin
        rw_addr  = beat0_addr;
        rw_wmode = we_q;
`ifdef MISALIGN_SPLIT_EN
        rw_wmask = mask16[7:0];
        rw_wdata = w128[63:0];
        state_d  = cross_q ? ACC1 : RESP;
`else
        rw_wmask = base_mask << o;
        rw_wdata = wdata_q << {o, 3'b000};
        state_d  = RESP;
`endif
      end
`ifdef MISALIGN_SPLIT_EN
      ACC1: begin
        rw_addr  = beat1_addr;
        rw_wmode = we_q;
        rw_wmask = mask16[15:8];
        rw_wdata = w128[127:64];
        state_d  = RESP;
      end
`else
      ACC1: state_d = IDLE;
`endif
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (we_q || err_q) ? '0 : ld_ext;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, load-beat latching and the held RAM address.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      lo_q        <= '0;
      last_addr_q <= '0;
`ifdef MISALIGN_SPLIT_EN
      hi_q        <= '0;
`endif
    end else begin
      last_addr_q <= rw_addr;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr[ADDR_W-1:0];
        wdata_q <= req_wdata;
        err_q   <= req_bad;
      end
      if (state_q == ACC0 && !we_q) lo_q <= rw_rdata;
`ifdef MISALIGN_SPLIT_EN
      if (state_q == ACC1 && !we_q) hi_q <= rw_rdata;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit with a behavioural RAM model on the rw port.
// Expected RAM beats and responses are queued by the driver and checked by
// a negedge monitor; directed vectors cover both builds of MISALIGN_SPLIT_EN.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        rw_wmode;
  logic [32:0] rw_addr;
  logic [63:0] rw_wdata;
  logic [7:0]  rw_wmask;
  logic [63:0] rw_rdata;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic mem_clear;

  // Beat entry: {wmode, mask[7:0], addr[32:0], wdata[63:0]}
  logic [105:0] beat_q[$];
  // Response entry: {err, latency[7:0], rdata[63:0]}
  logic [72:0]  exp_q[$];
  int           acc_q[$];
  logic [105:0] mb;
  logic [72:0]  mr;
  int           ma;

  mem_access_unit dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .rw_wmode   (rw_wmode),
    .rw_addr    (rw_addr),
    .rw_wdata   (rw_wdata),
    .rw_wmask   (rw_wmask),
    .rw_rdata   (rw_rdata),
    .dbg_state  (dbg_state)
  );

  // Clock / cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: 128 words, combinational read, byte-masked write on posedge.
  logic [63:0] mem [0:127];
  assign rw_rdata = mem[rw_addr[9:3]];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 128; i++) mem[i] <= 64'h0;
    end else if (rw_wmode) begin
      for (int b = 0; b < 8; b++)
        if (rw_wmask[b]) mem[rw_addr[9:3]][8*b +: 8] <= rw_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_beat(input logic wm, input logic [7:0] m, input logic [32:0] a, input logic [63:0] d);
    beat_q.push_back({wm, m, a, d});
  endtask

  task automatic exp_resp(input logic e, input logic [7:0] lat, input logic [63:0] d);
    exp_q.push_back({e, lat, d});
  endtask

  // Driver: wait (bounded) for req_ready, present one request for one edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d);
    int t = 0;
    @(negedge clk);
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 64'(req_ready), 64'h1);
      return;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    @(posedge clk);
    acc_q.push_back(cyc);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 64'h0;
    req_wdata  = 64'h0;
  endtask

  // Monitor: RAM beats and responses are popped and compared as they appear.
  always @(negedge clk) begin
    if (rstn && (rw_wmask != 8'h00 || rw_wmode)) begin
      if (beat_q.size() == 0) begin
        chk("unexpected_beat", {31'h0, rw_addr}, 64'hFFFF_FFFF);
      end else begin
        mb = beat_q.pop_front();
        chk("beat_wmode", 64'(rw_wmode), 64'(mb[105]));
        chk("beat_wmask", 64'(rw_wmask), 64'(mb[104:97]));
        chk("beat_addr",  64'(rw_addr),  64'(mb[96:64]));
        chk("beat_wdata", rw_wdata, mb[63:0]);
      end
    end
    if (rstn && resp_valid) begin
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        chk("unexpected_resp", resp_rdata, ~resp_rdata);
      end else begin
        mr = exp_q.pop_front();
        ma = acc_q.pop_front();
        chk("resp_err",     64'(resp_err), 64'(mr[72]));
        chk("resp_rdata",   resp_rdata, mr[63:0]);
        chk("resp_latency", 64'(cyc - ma), 64'(mr[71:64]));
      end
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_ready"},  64'(req_ready),  64'h1);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'h0);
    chk({tag, "_resp_err"},   64'(resp_err),   64'h0);
    chk({tag, "_resp_rdata"}, resp_rdata,      64'h0);
    chk({tag, "_rw_wmode"},   64'(rw_wmode),   64'h0);
    chk({tag, "_rw_wmask"},   64'(rw_wmask),   64'h0);
    chk({tag, "_rw_wdata"},   rw_wdata,        64'h0);
    chk({tag, "_rw_addr"},    64'(rw_addr),    64'h0);
  endtask

`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  initial begin
    int t;
    rstn       = 1'b0;
    mem_clear  = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 64'h0;
    req_wdata  = 64'h0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    mem_clear = 1'b0;
    rstn      = 1'b1;
    @(negedge clk);

    // Aligned SD, then loads of varied size/sign/offset.
    exp_beat(1, 8'hFF, 33'h100, 64'h1122334455667788); exp_resp(0, 2, 64'h0);
    issue(1, 3'd3, 64'h100, 64'h1122334455667788);
    exp_beat(0, 8'h01, 33'h100, 64'h0); exp_resp(0, 2, 64'hFFFFFFFFFFFFFF88);
    issue(0, 3'd0, 64'h100, 64'h0);
    exp_beat(0, 8'h80, 33'h100, 64'h0); exp_resp(0, 2, 64'h11);
    issue(0, 3'd4, 64'h107, 64'h0);
    exp_beat(0, 8'h0C, 33'h100, 64'h0); exp_resp(0, 2, 64'h5566);
    issue(0, 3'd5, 64'h102, 64'h0);
    exp_beat(0, 8'hFF, 33'h100, 64'h0); exp_resp(0, 2, 64'h1122334455667788);
    issue(0, 3'd3, 64'h100, 64'h0);
    exp_beat(0, 8'hF0, 33'h100, 64'h0); exp_resp(0, 2, 64'h11223344);
    issue(0, 3'd2, 64'h104, 64'h0);

    // Negative halfword and byte through SH / SB with lane shifting.
    exp_beat(1, 8'h03, 33'h110, 64'h00000000FFFF8001); exp_resp(0, 2, 64'h0);
    issue(1, 3'd1, 64'h110, 64'hFFFF8001);
    exp_beat(0, 8'h03, 33'h110, 64'h0); exp_resp(0, 2, 64'hFFFFFFFFFFFF8001);
    issue(0, 3'd1, 64'h110, 64'h0);
    exp_beat(0, 8'h03, 33'h110, 64'h0); exp_resp(0, 2, 64'h8001);
    issue(0, 3'd5, 64'h110, 64'h0);
    exp_beat(1, 8'h20, 33'h110, 64'h0000A50000000000); exp_resp(0, 2, 64'h0);
    issue(1, 3'd0, 64'h115, 64'hA5);
    exp_beat(0, 8'h20, 33'h110, 64'h0); exp_resp(0, 2, 64'hFFFFFFFFFFFFFFA5);
    issue(0, 3'd0, 64'h115, 64'h0);

    // Illegal encodings: no beat, error one cycle after accept.
    exp_resp(1, 1, 64'h0);
    issue(0, 3'd7, 64'h100, 64'h0);
    exp_resp(1, 1, 64'h0);
    issue(1, 3'd4, 64'h100, 64'hFF);

    // Boundary-crossing SW then LW at 0x106.
    if (SPLIT) begin
      exp_beat(1, 8'hC0, 33'h100, 64'hCCDD000000000000);
      exp_beat(1, 8'h03, 33'h108, 64'h000000000000AABB);
      exp_resp(0, 3, 64'h0);
      issue(1, 3'd2, 64'h106, 64'hAABBCCDD);
      exp_beat(0, 8'hC0, 33'h100, 64'h0);
      exp_beat(0, 8'h03, 33'h108, 64'h0);
      exp_resp(0, 3, 64'hFFFFFFFFAABBCCDD);
      issue(0, 3'd2, 64'h106, 64'h0);
    end else begin
      exp_resp(1, 1, 64'h0);
      issue(1, 3'd2, 64'h106, 64'hAABBCCDD);
      exp_resp(1, 1, 64'h0);
      issue(0, 3'd2, 64'h106, 64'h0);
    end

    // Within-word misaligned LW is legal in both builds.
    exp_beat(0, 8'h3C, 33'h100, 64'h0); exp_resp(0, 2, 64'h33445566);
    issue(0, 3'd2, 64'h102, 64'h0);

    // Drain outstanding expectations before the reset test.
    t = 0;
    while ((exp_q.size() != 0 || beat_q.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_resp_q", 64'(exp_q.size()), 64'h0);
    chk("drain_beat_q", 64'(beat_q.size()), 64'h0);
    chk("mem_100", mem[32], SPLIT ? 64'hCCDD334455667788 : 64'h1122334455667788);
    chk("mem_108", mem[33], SPLIT ? 64'h000000000000AABB : 64'h0);
    chk("mem_110", mem[34], 64'h0000A5000000_8001);

    // Split SD at 0x1FC with reset pulled during the second beat.
    if (SPLIT) begin
      exp_beat(1, 8'hF0, 33'h1F8, 64'h0506070800000000);
      issue(1, 3'd3, 64'h1FC, 64'h0102030405060708);
      @(posedge clk);
      #1;
      rstn = 1'b0;
      #1;
      chk_idle_outputs("abort");
      acc_q.delete();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk_idle_outputs("post_abort");
      chk("beat_q_after_abort", 64'(beat_q.size()), 64'h0);
      chk("mem_1f8", mem[63], 64'h0506070800000000);
      chk("mem_200", mem[64], 64'h0);
      exp_beat(0, 8'hFF, 33'h1F8, 64'h0); exp_resp(0, 2, 64'h0506070800000000);
      issue(0, 3'd3, 64'h1F8, 64'h0);
    end else begin
      exp_resp(1, 1, 64'h0);
      issue(1, 3'd3, 64'h1FC, 64'h0102030405060708);
      repeat (3) @(negedge clk);
      chk("mem_1f8", mem[63], 64'h0);
      chk("mem_200", mem[64], 64'h0);
    end

    t = 0;
    while ((exp_q.size() != 0 || beat_q.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("final_resp_q", 64'(exp_q.size()), 64'h0);
    chk("final_beat_q", 64'(beat_q.size()), 64'h0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit directly upstream of the unified RAM's rw port; converts CPU data-memory requests (RV64 LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD) into RAM word accesses.
- Computes 8-byte-aligned word address, byte-lane write mask and shifted write data; extracts and sign/zero-extends load data.
- Accesses that cross an 8-byte boundary are either split into two RAM beats or rejected, selected by the optional feature.
- RAM rw port: combinational read, write on posedge clk.

Parameters:
- ADDR_W, 33, RAM address width driven on rw_addr.
- XLEN, 64, data width; fixed at 64, other values not supported.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- req_valid  input  1  CPU request valid
- req_ready  output  1  unit can accept a request
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  size/sign: 0 B, 1 H, 2 W, 3 D, 4 BU, 5 HU, 6 WU; 7 illegal
- req_addr  input  64  byte address; bits [63:33] ignored
- req_wdata  input  64  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  64  extended load data; 0 for stores and errors
- resp_err  output  1  request rejected, valid with resp_valid
- rw_wmode  output  1  to RAM write enable
- rw_addr  output  33  to RAM, low 3 bits always 0
- rw_wdata  output  64  to RAM, lane-shifted store data
- rw_wmask  output  8  to RAM byte mask
- rw_rdata  input  64  from RAM

Behaviour:
- Reset (rstn low, async): state IDLE; all outputs 0 except req_ready=1; internal buffers cleared.
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: req_ready=1. On req_valid at posedge, capture we/funct3/addr/wdata.
  - funct3=7, or store with funct3 4..6: go to RESP with err.
  - Boundary crossing (addr[2:0]+size>8) without split enabled: go to RESP with err.
  - Otherwise go to ACC0.
- req_ready=0 in ACC0, ACC1 and RESP.
- Lane computation: o=addr[2:0]; size s in {1,2,4,8}; base mask (1<<s)-1.
  - 16-bit mask M=base<<o; 128-bit data W=wdata<<(8*o).
  - Beat0 uses M[7:0] and W[63:0]; beat1 uses M[15:8] and W[127:64].
- ACC0: rw_addr={addr[32:3],3'b0}, rw_wmask=M[7:0], rw_wdata=W[63:0], rw_wmode=we. Loads latch rw_rdata into lo at posedge.
  - Next state ACC1 if crossing, else RESP.
- ACC1: rw_addr=beat0 address+8 (wraps mod 2^33), mask/data from the beat1 half. Loads latch rw_rdata into hi. Next state RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - Loads: resp_rdata = ({hi,lo}>>(8*o)) truncated to s bytes; sign-extend for funct3 0..2, zero-extend for 3..6.
  - Errors: no RAM beat occurs (rw_wmode never asserted), resp_err=1, resp_rdata=0.
- rw_wmode, rw_wmask and rw_wdata are 0 outside ACC0/ACC1; rw_addr holds its last value.
- Latency from accept edge to resp_valid: aligned access 2 cycles; split access 3 cycles; error 1 cycle.
- No response back-pressure: the CPU must sample resp_valid.
- Reset mid-operation aborts immediately. A write already committed in ACC0 stays in RAM; the pending ACC1 beat is never issued.

Optional Feature:
- MISALIGN_SPLIT_EN
  - Defined: boundary-crossing accesses execute as two beats (ACC0 then ACC1).
  - Undefined: crossing accesses complete in RESP with resp_err=1; no RAM write or read beat is issued, and the ACC1 state logic is not built.
  - Within-word misaligned accesses (e.g. LW at 0x102) are legal in both builds.

Test Plan:
- SD addr 0x100 data 0x1122334455667788 -> ACC0 shows rw_addr 0x100, rw_wmask 0xFF, rw_wmode 1; resp_valid 2 cycles after accept, resp_err 0.
- LB 0x100 after the above -> resp_rdata 0xFFFFFFFFFFFFFF88. LBU 0x107 -> 0x11. LHU 0x102 -> 0x5566.
- SW addr 0x106 data 0xAABBCCDD (split build) -> beat0: addr 0x100, mask 0xC0, wdata[63:48]=0xCCDD; beat1: addr 0x108, mask 0x03, wdata[15:0]=0xAABB. Then LW 0x106 -> 0xFFFFFFFFAABBCCDD, resp_valid 3 cycles after accept.
- Same SW without MISALIGN_SPLIT_EN -> resp_err=1 one cycle after accept; rw_wmode stays 0; word 0x100 unchanged.
- funct3=7 load, and SB-type store with funct3=4 -> resp_err=1, resp_rdata 0, no RAM access.
- Split SD at 0x1FC, rstn pulled low during ACC1 -> word 0x1F8 updated in bytes 4..7; word 0x200 unchanged; after release req_ready=1 and all RAM-side outputs 0.
